// File: rtl/regfile_exec.sv
// Register file and sequencer for the external 16-bit add/sub stage.
// Each command is read, executed, written back and reported on a one-cycle strobe.
module regfile_exec #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] as_d1,
    output logic [DATA_W-1:0] as_d2,
    output logic              as_sign,
    input  logic [DATA_W-1:0] as_out,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_ovf,
    output logic              rsp_zero
);

    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_RD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WB
    } state_t;

    state_t state, next_state;

    logic [DATA_W-1:0] regs [NREG];
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              accept;
    logic              ovf_calc;

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    next_state = (cmd_op == OP_LDI) ? WB : READ;
                end
            end
            READ:    next_state = (op_q == OP_RD) ? WB : EXEC;
            EXEC:    next_state = WB;
            WB:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Signed overflow judged on operand and result sign bits of the captured stage output.
    always_comb begin
        ovf_calc = 1'b0;
        if (op_q == OP_SUB) begin
            ovf_calc = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (as_out[DATA_W-1] != op_a[DATA_W-1]);
        end else begin
            ovf_calc = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (as_out[DATA_W-1] != op_a[DATA_W-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            op_q      <= OP_LDI;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            as_d1     <= '0;
            as_d2     <= '0;
            as_sign   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_ovf   <= 1'b0;
            rsp_zero  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= cmd_op;
                        rd_q  <= cmd_rd;
                        rs1_q <= cmd_rs1;
                        rs2_q <= cmd_rs2;
                        if (cmd_op == OP_LDI) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= cmd_imm;
                            rsp_ovf   <= 1'b0;
                            rsp_zero  <= (cmd_imm == '0);
                        end
                    end
                end
                READ: begin
                    op_a <= regs[rs1_q];
                    op_b <= regs[rs2_q];
                    if (op_q == OP_RD) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= regs[rs1_q];
                        rsp_ovf   <= 1'b0;
                        rsp_zero  <= (regs[rs1_q] == '0);
                    end else begin
                        as_d1   <= regs[rs1_q];
                        as_d2   <= regs[rs2_q];
                        as_sign <= (op_q == OP_SUB);
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= as_out;
                    rsp_ovf   <= ovf_calc;
                    rsp_zero  <= (as_out == '0);
                end
                WB: begin
                    // rsp_data doubles as the result register for write-back.
                    if (op_q != OP_RD) begin
                        regs[rd_q] <= rsp_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
